// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone register-file slave: FSM states,
// select-lane width derivation and lane-to-bit mask expansion.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } wb_state_e;

    localparam int WAIT_CNT_W = 4;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_SEL_W  = 256;

    function automatic int sel_width(input int data_w, input int granule);
        return data_w / granule;
    endfunction

    // Expands one select bit per lane into a per-bit write mask.
    function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_SEL_W-1:0] sel,
                                                        input int granule);
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < MAX_DATA_W; b++) begin
            if (sel[b / granule]) begin
                mask[b] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_reg_cell.sv
// One register of the file: lane-masked bus write, write-1-to-clear with
// hardware sticky set, or a read-only window onto a live status word.
module wb_reg_cell
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter bit                    IS_RO       = 1'b0,
    parameter bit                    IS_W1C      = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [DATA_WIDTH-1:0] wr_mask_i,
    input  logic [DATA_WIDTH-1:0] set_i,
    input  logic [DATA_WIDTH-1:0] status_i,
    output logic [DATA_WIDTH-1:0] value_o
);

    // Not every flavour of cell consumes every input.
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, wr_en_i, wr_data_i, wr_mask_i, set_i, status_i};

    if (IS_RO) begin : g_ro
        assign value_o = status_i;
    end else begin : g_store
        logic [DATA_WIDTH-1:0] val_q;
        logic [DATA_WIDTH-1:0] val_d;

        always_comb begin
            val_d = val_q;
            if (IS_W1C) begin
                if (wr_en_i) begin
                    val_d = val_q & ~(wr_data_i & wr_mask_i);
                end
                // Applied after the clear so a simultaneous set wins.
                val_d = val_d | set_i;
            end else if (wr_en_i) begin
                val_d = (val_q & ~wr_mask_i) | (wr_data_i & wr_mask_i);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                val_q <= RESET_VALUE;
            end else begin
                val_q <= val_d;
            end
        end

        assign value_o = val_q;
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave exposing NUM_REGS registers: address decode with
// error response, programmable wait states, and registered ack/err/data.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    GRANULE     = 8,
    parameter int                    NUM_REGS    = 8,
    parameter int unsigned           BASE_ADDR   = 0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]   W1C_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   SEL_WIDTH   = sel_width(DATA_WIDTH, GRANULE)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          adr_i,
    input  logic [DATA_WIDTH-1:0]          dat_i,
    output logic [DATA_WIDTH-1:0]          dat_o,
    input  logic [SEL_WIDTH-1:0]           sel_i,
    input  logic                           we_i,
    input  logic                           cyc_i,
    input  logic                           stb_i,
    output logic                           ack_o,
    output logic                           err_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] set_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int                    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] NREGS = ADDR_WIDTH'(NUM_REGS);

    wb_state_e               state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    latch, commit;

    logic                    hit_q, we_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [DATA_WIDTH-1:0]   wdat_q;

    logic                    ack_q, err_q;
    logic [DATA_WIDTH-1:0]   rdat_q;
    logic [NUM_REGS-1:0]     wr_pulse_q;

    // Extra top bit catches addresses below the base.
    logic [ADDR_WIDTH:0]     offset;
    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;

    assign offset  = {1'b0, adr_i} - {1'b0, BASE};
    assign dec_hit = !offset[ADDR_WIDTH] && (offset[ADDR_WIDTH-1:0] < NREGS);
    assign dec_idx = offset[IDX_W-1:0];

    // Zero-wait accesses commit straight from IDLE, so use the live bus there.
    logic                    acc_hit, acc_we;
    logic [IDX_W-1:0]        acc_idx;
    logic [SEL_WIDTH-1:0]    acc_sel;
    logic [DATA_WIDTH-1:0]   acc_dat;

    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_hit = dec_hit;
            acc_we  = we_i;
            acc_idx = dec_idx;
            acc_sel = sel_i;
            acc_dat = dat_i;
        end else begin
            acc_hit = hit_q;
            acc_we  = we_q;
            acc_idx = idx_q;
            acc_sel = sel_q;
            acc_dat = wdat_q;
        end
    end

    logic [DATA_WIDTH-1:0] wr_mask;
    assign wr_mask = DATA_WIDTH'(lane_mask(MAX_SEL_W'(acc_sel), GRANULE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    latch = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] cell_val [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   wr_pulse_d;

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
        assign wr_hit[n]     = commit && acc_hit && acc_we && (acc_idx == IDX_W'(n));
        assign wr_pulse_d[n] = wr_hit[n] && !RO_MASK[n];

        wb_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .IS_RO      (RO_MASK[n]),
            .IS_W1C     (W1C_MASK[n] && !RO_MASK[n]),
            .RESET_VALUE(RESET_VALUE)
        ) u_cell (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_en_i  (wr_hit[n]),
            .wr_data_i(acc_dat),
            .wr_mask_i(wr_mask),
            .set_i    (set_i[n*DATA_WIDTH +: DATA_WIDTH]),
            .status_i (status_i[n*DATA_WIDTH +: DATA_WIDTH]),
            .value_o  (cell_val[n])
        );

        assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = cell_val[n];
    end

    logic [DATA_WIDTH-1:0] rd_val;
    assign rd_val = cell_val[acc_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= commit && acc_hit;
            err_q      <= commit && !acc_hit;
            rdat_q     <= (commit && acc_hit && !acc_we) ? rd_val : '0;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch) begin
            hit_q  <= dec_hit;
            we_q   <= we_i;
            idx_q  <= dec_idx;
            sel_q  <= sel_i;
            wdat_q <= dat_i;
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign dat_o      = rdat_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: doc/wb_slave_regfile.md
# wb_slave_regfile

Parametrised Wishbone classic slave holding `NUM_REGS` word registers. It generalises the single-register slave with:
- address decode over a base/range, with an error response outside it;
- per-register modes: read/write, read-only status, write-1-to-clear;
- programmable wait states;
- hardware-side set, status and write-strobe ports.

It sits between a Wishbone master (CPU or bench BFM) and a peripheral's control/status logic.

## Interface
- `ADDR_WIDTH`, 16, address bus width
- `DATA_WIDTH`, 32, data bus width
- `GRANULE`, 8, bits per select lane; `SEL_WIDTH = DATA_WIDTH/GRANULE`
- `NUM_REGS`, 8, number of registers, ≥1
- `BASE_ADDR`, 0, word address of register 0
- `WAIT_STATES`, 0, extra cycles before ack/err, 0..15
- `RO_MASK`, 0, `NUM_REGS` bits; bit n=1 makes reg n read-only (reads `status_i`)
- `W1C_MASK`, 0, `NUM_REGS` bits; bit n=1 makes reg n write-1-to-clear (RO_MASK takes priority)
- `RESET_VALUE`, 0, reset value of every RW/W1C register
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high
- `adr_i`  in  ADDR_WIDTH  word address
- `dat_i`  in  DATA_WIDTH  write data
- `dat_o`  out  DATA_WIDTH  read data
- `sel_i`  in  SEL_WIDTH  lane selects
- `we_i`  in  1  write enable
- `cyc_i`  in  1  cycle valid
- `stb_i`  in  1  strobe
- `ack_o`  out  1  normal termination
- `err_o`  out  1  error termination
- `regs_o`  out  NUM_REGS*DATA_WIDTH  current register contents, reg n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- `status_i`  in  NUM_REGS*DATA_WIDTH  live values for RO registers
- `set_i`  in  NUM_REGS*DATA_WIDTH  per-bit sticky set for W1C registers
- `wr_pulse_o`  out  NUM_REGS  one-cycle strobe when reg n is bus-written

## Operation
- Index is `adr_i − BASE_ADDR`; it is in range iff `adr_i ≥ BASE_ADDR` and index < `NUM_REGS`.
- FSM states: IDLE, WAIT, RESP.
  - **IDLE:** `cyc_i&stb_i` latches address, `we_i`, `sel_i`, data and the decode result. Next state is WAIT if `WAIT_STATES>0`, else RESP.
  - **WAIT:** a counter runs from `WAIT_STATES−1` down to 0, then goes to RESP. If `cyc_i` or `stb_i` drops, the access is aborted: return to IDLE with no response and no side effect.
  - **RESP:** `ack_o` or `err_o` is high for exactly one cycle, then the FSM returns to IDLE. IDLE re-samples `stb_i` on the next cycle, so a new access can start one cycle after the response.
- RW write: lanes with `sel_i[k]=1` take `dat_i` lane k; other lanes are held.
- W1C write: in selected lanes, bits written 1 are cleared.
- `set_i` ORs into W1C registers on every cycle. Set wins over a simultaneous clear of the same bit.
- RO write: acked, data ignored, no `wr_pulse_o`.
- Reads return the full word regardless of `sel_i`. RO registers return `status_i` sampled at the RESP edge.
- Out-of-range access: `err_o` instead of `ack_o`, `dat_o=0`, no state change.
- `dat_o` is 0 whenever `ack_o` is low.
- Reset: FSM to IDLE; `ack_o`, `err_o`, `dat_o`, `wr_pulse_o` = 0; RW/W1C registers = `RESET_VALUE`. Reset asserted mid-access abandons the access silently.

## Timing
- Latency: `stb_i` sampled at edge t → `ack_o`/`err_o` high during cycle t+1+`WAIT_STATES`.
- Register write commits on the same edge that raises `ack_o`. `regs_o` shows the new value during the ack cycle. `wr_pulse_o[n]` is coincident with `ack_o`.
- Minimum spacing between back-to-back accesses with `stb_i` held: 2+`WAIT_STATES` cycles per transfer.
- Read-modify-write (`cyc_i` held, `stb_i` dropped between phases) needs no special handling. Each phase is an independent access.

## Structure
- Shared package `wb_pkg`:
  - FSM state enum;
  - `SEL_WIDTH` derivation;
  - lane-mask function (`sel` → bit mask);
  - wait-counter width constant (4 bits).
- Sub-module `wb_reg_cell`, one instance per register via generate. It handles:
  - lane-masked write;
  - the W1C/set merge;
  - the RO mux to `status_i`;
  - the reset value.
- The top level holds only the decode, FSM and read mux.

## Test plan
- Reset, then read reg 0 with `BASE_ADDR`=0x10 at `adr_i`=0x10 → `ack_o` at t+1, `dat_o`=0x00000000.
- Write reg 2 (0x12) with 0xDEADBEEF, `sel_i`=0xF. Then write 0x11223344 with `sel_i`=0x5. Then read → 0xDE22BE44; `wr_pulse_o[2]` pulses twice.
- W1C reg 3: drive `set_i` bit 0x000000F0 one cycle → read 0x000000F0. Write 0x00000030 → read 0x000000C0. Write 0x00000040 in the same cycle as a set on bit 6 → bit 6 stays 1.
- RO reg 4 with `status_i`=0xCAFEF00D: read → 0xCAFEF00D. Write 0x0 → acked, next read still 0xCAFEF00D, no `wr_pulse_o`.
- Access `adr_i`=0x18 (index 8, `NUM_REGS`=8) and 0x0F → `err_o` one cycle, `ack_o`=0, `dat_o`=0. A write there alters no register.
- `WAIT_STATES`=3: response at t+4. Dropping `stb_i` at t+2 → no ack, no write. `rst_i` pulsed at t+2 → no response, all registers back to `RESET_VALUE`.
